// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: input conditioning, RUN/PAUSE/ADJ mode FSM and the timing
// pulses that drive the BCD counters and the 7-segment scan.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DIV_1HZ         = 100000000,
  parameter int DIV_2HZ         = 50000000,
  parameter int SCAN_DIV        = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       carry_en,
  output logic       clr_cnt,
  output logic       paused,
  output logic       adj_mode,
  output logic       blink_min,
  output logic       blink_sec,
  output logic [1:0] digit_sel
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int D1W = (DIV_1HZ > 1) ? $clog2(DIV_1HZ) : 1;
  localparam int D2W = (DIV_2HZ > 1) ? $clog2(DIV_2HZ) : 1;
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [D1W-1:0] D1_MAX = D1W'(DIV_1HZ - 1);
  localparam logic [D2W-1:0] D2_MAX = D2W'(DIV_2HZ - 1);
  localparam logic [SCW-1:0] SC_MAX = SCW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_ADJ   = 2'd2
  } state_t;

  logic [3:0]     meta_r;
  logic [3:0]     sync_r;
  logic [1:0]     acc_r;
  logic [1:0]     evt_r;
  logic [DBW-1:0] db_cnt_r [2];
  state_t         state_r;
  state_t         state_s;
  logic           run_r;
  logic           run_s;
  logic [D1W-1:0] div1_r;
  logic [D1W-1:0] div1_s;
  logic [D2W-1:0] div2_r;
  logic [D2W-1:0] div2_s;
  logic           phase_r;
  logic           phase_s;
  logic [SCW-1:0] scan_r;
  logic           tick1_s;
  logic           tick2_s;
  logic           pause_evt_s;
  logic           reset_evt_s;
  logic           adj_s;
  logic           sel_s;

  assign pause_evt_s = evt_r[0];
  assign reset_evt_s = evt_r[1];
  assign adj_s       = sync_r[2];
  assign sel_s       = sync_r[3];

  // Two-flop synchronizers for every raw board input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 4'b0000;
      sync_r <= 4'b0000;
    end else begin
      meta_r <= {sw_sel, sw_adj, btn_reset, btn_pause};
      sync_r <= meta_r;
    end
  end

  // Button debounce; an accepted rising level yields a one-cycle event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= 2'b00;
      evt_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= {DBW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] != acc_r[i]) begin
          if (db_cnt_r[i] == DB_MAX) begin
            acc_r[i]    <= sync_r[i];
            evt_r[i]    <= sync_r[i];
            db_cnt_r[i] <= {DBW{1'b0}};
          end else begin
            evt_r[i]    <= 1'b0;
            db_cnt_r[i] <= db_cnt_r[i] + DBW'(1);
          end
        end else begin
          evt_r[i]    <= 1'b0;
          db_cnt_r[i] <= {DBW{1'b0}};
        end
      end
    end
  end

  // Run flag and mode next-state; RUN/PAUSE track the flag in the same cycle it toggles
  always_comb begin
    run_s   = run_r ^ pause_evt_s;
    state_s = ST_PAUSE;
    case (state_r)
      ST_PAUSE, ST_RUN, ST_ADJ: begin
        if (adj_s) begin
          state_s = ST_ADJ;
        end else if (run_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      default: begin
        state_s = ST_PAUSE;
      end
    endcase
  end

  // 1 Hz divider: counts only in RUN, holds elsewhere, cleared by a reset event
  always_comb begin
    div1_s  = div1_r;
    tick1_s = 1'b0;
    if (state_r == ST_RUN) begin
      if (div1_r == D1_MAX) begin
        div1_s  = {D1W{1'b0}};
        tick1_s = 1'b1;
      end else begin
        div1_s = div1_r + D1W'(1);
      end
    end else begin
      div1_s = div1_r;
    end
    if (reset_evt_s) begin
      div1_s = {D1W{1'b0}};
    end else begin
      div1_s = div1_s;
    end
  end

  // 2 Hz adjust divider and blink phase, both restarted on ADJ entry
  always_comb begin
    div2_s  = div2_r;
    phase_s = phase_r;
    tick2_s = 1'b0;
    if ((state_s == ST_ADJ) && (state_r != ST_ADJ)) begin
      div2_s  = {D2W{1'b0}};
      phase_s = 1'b0;
    end else if (state_r == ST_ADJ) begin
      if (div2_r == D2_MAX) begin
        div2_s  = {D2W{1'b0}};
        phase_s = ~phase_r;
        tick2_s = 1'b1;
      end else begin
        div2_s = div2_r + D2W'(1);
      end
    end else begin
      phase_s = 1'b0;
    end
  end

  // State, dividers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_PAUSE;
      run_r     <= 1'b0;
      div1_r    <= {D1W{1'b0}};
      div2_r    <= {D2W{1'b0}};
      phase_r   <= 1'b0;
      inc_sec   <= 1'b0;
      inc_min   <= 1'b0;
      carry_en  <= 1'b0;
      clr_cnt   <= 1'b0;
      paused    <= 1'b0;
      adj_mode  <= 1'b0;
      blink_min <= 1'b0;
      blink_sec <= 1'b0;
    end else begin
      state_r   <= state_s;
      run_r     <= run_s;
      div1_r    <= div1_s;
      div2_r    <= div2_s;
      phase_r   <= phase_s;
      // A clear in the same cycle as a tick wins over the increment
      inc_sec   <= ~reset_evt_s & (tick1_s | (tick2_s & sel_s));
      inc_min   <= ~reset_evt_s & tick2_s & ~sel_s;
      carry_en  <= (state_s != ST_ADJ);
      clr_cnt   <= reset_evt_s;
      paused    <= ~run_s;
      adj_mode  <= (state_s == ST_ADJ);
      blink_min <= (state_s == ST_ADJ) & phase_s & ~sel_s;
      blink_sec <= (state_s == ST_ADJ) & phase_s & sel_s;
    end
  end

  // Free-running digit scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_r    <= {SCW{1'b0}};
      digit_sel <= 2'd0;
    end else if (scan_r == SC_MAX) begin
      scan_r    <= {SCW{1'b0}};
      digit_sel <= digit_sel + 2'd1;
    end else begin
      scan_r    <= scan_r + SCW'(1);
      digit_sel <= digit_sel;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small divider parameters;
// expected timings are hand-derived from the debounce and divider latencies.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_pause = 1'b0;
  logic       btn_reset = 1'b0;
  logic       sw_adj = 1'b0;
  logic       sw_sel = 1'b0;
  logic       inc_sec, inc_min, carry_en, clr_cnt, paused, adj_mode;
  logic       blink_min, blink_sec;
  logic [1:0] digit_sel;

  int n_cmp = 0;
  int n_bad = 0;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DIV_1HZ(10),
    .DIV_2HZ(5),
    .SCAN_DIV(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_pause(btn_pause), .btn_reset(btn_reset),
    .sw_adj(sw_adj), .sw_sel(sw_sel), .inc_sec(inc_sec), .inc_min(inc_min),
    .carry_en(carry_en), .clr_cnt(clr_cnt), .paused(paused), .adj_mode(adj_mode),
    .blink_min(blink_min), .blink_sec(blink_sec), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {inc_sec, inc_min, carry_en, clr_cnt, paused, adj_mode,
              blink_min, blink_sec, digit_sel}, 32'd0);
  endtask

  // n cycles in RUN; inc_sec high only on the last, carry_en always 1
  task automatic expect_tick(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk(tag, {inc_sec, inc_min, carry_en}, (i == n) ? 3'b101 : 3'b001);
    end
  endtask

  // Clean 8-cycle press; accepted edge reaches paused on the 7th edge
  task automatic press_pause(input logic exp_after);
    btn_pause = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 6) chk("pause_pre", paused, !exp_after);
      if (k == 7) chk("pause_lat", paused, exp_after);
    end
    btn_pause = 1'b0;
  endtask

  task automatic wait_tick(input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (inc_sec !== 1'b1 && i < budget);
    chk("tick_seen", inc_sec, 1'b1);
  endtask

  // n cycles of ADJ ending in a wrap; ph is the blink phase after the wrap
  task automatic adj_tick(input int n, input logic sel, input logic ph);
    logic p;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      p = (i == n) ? ph : !ph;
      chk("adj_period", {adj_mode, carry_en, inc_min, inc_sec, blink_min, blink_sec},
          {1'b1, 1'b0, (i == n) && !sel, (i == n) && sel, p && !sel, p && sel});
    end
  endtask

  initial begin
    // 1. power-up and start
    repeat (3) @(negedge clk);
    chk_all_zero("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk("por_paused", paused, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("por_noinc", {inc_sec, inc_min}, 2'b00);
    end
    press_pause(1'b0);
    expect_tick(9, "first_tick");
    expect_tick(10, "tick_period");
    expect_tick(10, "tick_period");

    // 2. bounce rejection
    for (int g = 0; g < 20; g++) begin
      btn_pause = 1'b1;
      for (int j = 0; j <= (g % 3); j++) begin
        @(negedge clk);
        chk("glitch_paused", paused, 1'b0);
      end
      btn_pause = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("glitch_paused", paused, 1'b0);
      end
    end
    press_pause(1'b1);
    repeat (8) begin
      @(negedge clk);
      chk("paused_noinc", {paused, inc_sec}, 2'b10);
    end
    press_pause(1'b0);
    repeat (8) @(negedge clk);

    // 3. fraction preservation: pause lands with the divider at 7
    wait_tick(15);
    press_pause(1'b1);
    repeat (50) begin
      @(negedge clk);
      chk("frac_hold", {paused, inc_sec}, 2'b10);
    end
    press_pause(1'b0);
    expect_tick(2, "frac_resume");

    // 4. adjust mode
    sw_adj = 1'b1;
    sw_sel = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("adj_entry", {adj_mode, carry_en}, (k == 3) ? 2'b10 : 2'b01);
    end
    adj_tick(5, 1'b0, 1'b1);
    adj_tick(5, 1'b0, 1'b0);
    sw_sel = 1'b1;
    adj_tick(5, 1'b1, 1'b1);
    sw_adj = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("adj_exit", {adj_mode, blink_min, blink_sec, paused},
          (k == 3) ? 4'b0000 : 4'b1010);
    end
    expect_tick(7, "adj_hold");

    // 5. clear event coinciding with a tick
    repeat (3) @(negedge clk);
    btn_reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("clr_collide", {clr_cnt, inc_sec, paused}, (k == 7) ? 3'b100 : 3'b000);
    end
    btn_reset = 1'b0;
    expect_tick(9, "clr_after");

    // 6. async reset mid-RUN, then scan sequence
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      chk("scan", digit_sel, (n / 3) % 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
